conv_enc_k7: RTL and testbench
==============================

# conv_enc_k7

Rate-1/2, constraint-length-7 convolutional encoder (generators 171/133 octal) for the FEC transmit chain. It sits directly downstream of the 8-to-1 parallel-to-serial converter and consumes its serial bit stream. It gates that stream with a request line, encodes one bit per cycle into a 2-bit coded symbol, and appends six zero tail bits per frame so the trellis terminates in state 0.

## Interface
Parameters:
- FRAME_BITS, 1504: information bits per frame (188 bytes × 8); legal range 1..65535.
- TAIL_BITS, 6: zero bits appended per frame; fixed at K−1, not overridable.

Ports:
- iclk  in  1  single clock; all logic on the rising edge.
- irst  in  1  reset, synchronous, active-low.
- idat  in  1  serial information bit from the P2S stage.
- ival  in  1  idat valid.
- isop  in  1  first bit of a frame; qualified by ival.
- oreq  out  1  request to upstream; a bit is accepted on any cycle with ival && oreq.
- ireq  in  1  downstream ready; a symbol may be produced on the next cycle only if ireq=1 this cycle.
- odat  out  2  coded symbol: odat[1] = G1 (171) parity, odat[0] = G2 (133) parity.
- oval  out  1  odat valid, one cycle per symbol.
- osop  out  1  with oval, marks the first symbol of a frame.
- oeop  out  1  with oval, marks the last tail symbol.
- oerr  out  1  one-cycle pulse when a frame is aborted by an early isop.

## Operation
- Encoder register sr[5:0]: sr[0] holds the most recent bit. With input bit u:
  - G1 = u^sr[0]^sr[1]^sr[2]^sr[5]
  - G2 = u^sr[1]^sr[2]^sr[4]^sr[5]
  - On every encoded bit: sr <= {sr[4:0], u}.
- State machine IDLE / DATA / TAIL; reset state is IDLE.
- IDLE:
  - oreq = ireq.
  - ival && oreq && !isop: bit discarded, no output.
  - ival && oreq && isop: sr cleared before encoding, bit encoded, symbol emitted with osop=1, bit_cnt=1, go to DATA.
  - If FRAME_BITS=1, go straight to TAIL.
- DATA:
  - oreq = ireq.
  - Each accepted bit is encoded and bit_cnt increments.
  - When the FRAME_BITS-th bit is accepted, go to TAIL with tail_cnt=0.
  - ival=0, or ireq=0: no symbol; state, sr and counters hold.
- TAIL:
  - oreq = 0.
  - Each cycle with ireq=1, a zero is encoded and tail_cnt increments.
  - The 6th tail symbol carries oeop=1; go to IDLE. sr is then all-zero by construction.
- Early isop in DATA (isop && ival && oreq before the frame completes):
  - oerr pulses with that bit's symbol.
  - The old frame is abandoned with no tail.
  - sr is cleared and the bit encoded as the first bit of a new frame (osop=1, bit_cnt=1).
- isop on the bit that would be the FRAME_BITS-th is also treated as an early isop: restart, no tail.
- bit_cnt width is $clog2(FRAME_BITS+1); tail_cnt is 3 bits. Neither wraps: both are reloaded on frame start or frame end.

## Timing
- Reset values: oval=0, osop=0, oeop=0, oerr=0, odat=2'b00, sr=0, counters=0, state=IDLE. oreq is combinational, so it follows ireq in IDLE after reset.
- oreq depends combinationally on ireq and state only, never on ival.
- Latency: a bit accepted in cycle n produces oval/odat/osop/oerr registered in cycle n+1.
- A tail symbol is issued in cycle n+1 when ireq=1 in cycle n.
- Throughput: one symbol per cycle. A frame needs FRAME_BITS+6 symbol cycles.
- The TAIL to IDLE transition takes one cycle. The first bit of the next frame may be accepted in the cycle immediately after the last tail symbol is issued.
- odat holds its last value when oval=0.
- Reset asserted mid-frame: all outputs return to reset values on the next edge, and the partial frame is discarded with no tail.

## Structure
- Shared package fec_pkg holds:
  - K=7, G1=7'o171, G2=7'o133;
  - TAIL_BITS;
  - typedef enum logic [1:0] {IDLE, DATA, TAIL} conv_state_t.
- Sub-module conv_k7_core holds sr and the parity logic, with ports iclk, irst, iclr, ien, ibit, odat[1:0] (combinational parity). The top level holds the FSM, counters, handshake and output registers.

## Test plan
- Impulse response, FRAME_BITS=1: isop+1 → seven symbols 11,10,11,11,00,01,11. osop on the first, oeop on the seventh.
- All-zero frame, FRAME_BITS=16: 22 symbols, all 00. osop/oeop exactly once each. oreq low for the 6 tail cycles.
- Backpressure: random ireq drops during DATA and TAIL. The symbol stream must equal a golden model, with no symbol while ireq was 0 the cycle before and no extra bit accepted.
- Early isop at bit 5 of a 16-bit frame: oerr pulses once. The next symbol carries osop. The restarted frame matches the reference encoding of a fresh frame.
- Back-to-back frames fed from the P2S converter with bytes 0xA5, 0x3C: the decoded Viterbi or golden-model output equals the input. There is zero gap between oeop and the next osop when ival is continuous.
- Reset pulse mid-TAIL: oval drops the next cycle. The next isop starts cleanly with sr=0 (the impulse check repeated gives 11,10,...).

Source files
------------

// File: rtl/fec_pkg.sv
// Shared definitions for the K=7 rate-1/2 convolutional encoder:
// generator polynomials, tail length, FSM states and the parity helper.
package fec_pkg;

  localparam int K = 7;
  localparam logic [6:0] G1 = 7'o171;
  localparam logic [6:0] G2 = 7'o133;
  localparam int TAIL_BITS = K - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } conv_state_t;

  // The window is ordered {u, sr[0], ..., sr[5]} so the octal generator's MSB taps the new bit.
  function automatic logic conv_parity(input logic [6:0] taps, input logic [6:0] win);
    conv_parity = ^(taps & win);
  endfunction

endpackage

// File: rtl/conv_k7_core.sv
// Encoder shift register and G1/G2 parity. The parity output is combinational;
// iclr makes the current bit see an all-zero history (start of a frame).
module conv_k7_core
  import fec_pkg::*;
(
  input  logic       iclk,
  input  logic       irst,
  input  logic       iclr,
  input  logic       ien,
  input  logic       ibit,
  output logic [1:0] odat
);

  logic [5:0] sr_r;
  logic [5:0] sr_eff_s;
  logic [6:0] win_s;

  // Parity of the incoming bit against the (possibly cleared) history
  always_comb begin
    sr_eff_s = iclr ? 6'd0 : sr_r;
    win_s    = {ibit, sr_eff_s[0], sr_eff_s[1], sr_eff_s[2],
                sr_eff_s[3], sr_eff_s[4], sr_eff_s[5]};
    odat     = {conv_parity(G1, win_s), conv_parity(G2, win_s)};
  end

  // History register shifts only on an encoded bit
  always_ff @(posedge iclk) begin
    if (!irst) begin
      sr_r <= 6'd0;
    end else if (ien) begin
      sr_r <= {sr_eff_s[4:0], ibit};
    end else begin
      sr_r <= sr_r;
    end
  end

endmodule

// File: rtl/conv_enc_k7.sv
// Rate-1/2 K=7 convolutional encoder top: request/valid handshake, frame FSM,
// bit/tail counters and registered symbol outputs around conv_k7_core.
module conv_enc_k7
  import fec_pkg::*;
#(
  parameter int FRAME_BITS = 1504
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       idat,
  input  logic       ival,
  input  logic       isop,
  output logic       oreq,
  input  logic       ireq,
  output logic [1:0] odat,
  output logic       oval,
  output logic       osop,
  output logic       oeop,
  output logic       oerr
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [2:0] LAST_TAIL = 3'(TAIL_BITS - 1);
  localparam bit ONE_BIT = (FRAME_BITS == 1);

  conv_state_t   state_r;
  logic [CW-1:0] bit_cnt_r;
  logic [2:0]    tail_cnt_r;
  logic          acc_s;
  logic          en_s;
  logic          clr_s;
  logic          bit_s;
  logic [1:0]    sym_s;

  conv_k7_core u_core (
    .iclk (iclk),
    .irst (irst),
    .iclr (clr_s),
    .ien  (en_s),
    .ibit (bit_s),
    .odat (sym_s)
  );

  // Handshake and encoder control; oreq never looks at ival
  always_comb begin
    oreq  = 1'b0;
    en_s  = 1'b0;
    clr_s = 1'b0;
    bit_s = 1'b0;
    acc_s = 1'b0;
    case (state_r)
      IDLE: begin
        oreq  = ireq;
        acc_s = ival && ireq;
        en_s  = acc_s && isop;
        clr_s = 1'b1;
        bit_s = idat;
      end
      DATA: begin
        oreq  = ireq;
        acc_s = ival && ireq;
        en_s  = acc_s;
        clr_s = isop;
        bit_s = idat;
      end
      TAIL: begin
        oreq  = 1'b0;
        en_s  = ireq;
        clr_s = 1'b0;
        bit_s = 1'b0;
      end
      default: begin
        oreq  = 1'b0;
        en_s  = 1'b0;
      end
    endcase
  end

  // Frame FSM, counters and registered outputs; odat only updates with a symbol
  always_ff @(posedge iclk) begin
    if (!irst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= {CW{1'b0}};
      tail_cnt_r <= 3'd0;
      odat       <= 2'b00;
      oval       <= 1'b0;
      osop       <= 1'b0;
      oeop       <= 1'b0;
      oerr       <= 1'b0;
    end else begin
      oval <= en_s;
      osop <= 1'b0;
      oeop <= 1'b0;
      oerr <= 1'b0;
      if (en_s) begin
        odat <= sym_s;
      end
      case (state_r)
        IDLE: begin
          if (en_s) begin
            osop       <= 1'b1;
            bit_cnt_r  <= CNT_ONE;
            tail_cnt_r <= 3'd0;
            state_r    <= ONE_BIT ? TAIL : DATA;
          end
        end
        DATA: begin
          if (acc_s) begin
            if (isop) begin
              osop      <= 1'b1;
              oerr      <= 1'b1;
              bit_cnt_r <= CNT_ONE;
            end else if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r  <= {CW{1'b0}};
              tail_cnt_r <= 3'd0;
              state_r    <= TAIL;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
          end
        end
        TAIL: begin
          if (ireq) begin
            if (tail_cnt_r == LAST_TAIL) begin
              oeop       <= 1'b1;
              tail_cnt_r <= 3'd0;
              bit_cnt_r  <= {CW{1'b0}};
              state_r    <= IDLE;
            end else begin
              tail_cnt_r <= tail_cnt_r + 3'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_k7.sv
// Self-checking bench for conv_enc_k7: a FRAME_BITS=1 instance (impulse/reset)
// and a FRAME_BITS=16 instance (frames, backpressure, early isop, back-to-back).
module tb_conv_enc_k7;

  typedef logic bits_t[$];
  typedef logic [4:0] sym_t;   // {odat[1:0], osop, oeop, oerr}

  localparam logic [6:0] G1_DLY = 7'b1001111;  // 171 octal as delays 0,1,2,3,6
  localparam logic [6:0] G2_DLY = 7'b1101101;  // 133 octal as delays 0,2,3,5,6

  logic iclk = 1'b0;
  logic irst = 1'b0;
  logic ival_v[2];
  logic idat_v[2];
  logic isop_v[2];
  logic ireq_v[2];
  logic a_oreq, a_oval, a_osop, a_oeop, a_oerr;
  logic b_oreq, b_oval, b_osop, b_oeop, b_oerr;
  logic [1:0] a_odat, b_odat;

  sym_t exp_a[$];
  sym_t exp_b[$];
  logic [1:0] obs_a[$];
  logic [1:0] last_odat[2];
  logic ireq_q[2];
  logic rst_q = 1'b0;
  logic bp = 1'b0;
  logic gap_chk = 1'b0;
  logic prev_eop_b = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int low_cnt = 0;

  always #5 iclk = ~iclk;

  conv_enc_k7 #(.FRAME_BITS(1)) dut_a (
    .iclk(iclk), .irst(irst), .idat(idat_v[0]), .ival(ival_v[0]), .isop(isop_v[0]),
    .oreq(a_oreq), .ireq(ireq_v[0]), .odat(a_odat), .oval(a_oval),
    .osop(a_osop), .oeop(a_oeop), .oerr(a_oerr)
  );

  conv_enc_k7 #(.FRAME_BITS(16)) dut_b (
    .iclk(iclk), .irst(irst), .idat(idat_v[1]), .ival(ival_v[1]), .isop(isop_v[1]),
    .oreq(b_oreq), .ireq(ireq_v[1]), .odat(b_odat), .oval(b_oval),
    .osop(b_osop), .oeop(b_oeop), .oerr(b_oerr)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Convolution of the frame (plus implicit zero tail) with the generator delays
  function automatic logic [1:0] model_sym(input bits_t b, input int t);
    logic g1, g2, u;
    logic [6:0] d1, d2;
    d1 = G1_DLY;
    d2 = G2_DLY;
    g1 = 1'b0;
    g2 = 1'b0;
    for (int j = 0; j < 7; j++) begin
      u = (t - j >= 0 && t - j < b.size()) ? b[t-j] : 1'b0;
      g1 ^= u & d1[j];
      g2 ^= u & d2[j];
    end
    return {g1, g2};
  endfunction

  function automatic void push_frame(input int sel, input bits_t b, input bit tail, input bit err);
    int tot;
    sym_t e;
    tot = b.size() + (tail ? 6 : 0);
    for (int t = 0; t < tot; t++) begin
      e = {model_sym(b, t), t == 0, tail && (t == tot - 1), err && (t == 0)};
      if (sel == 0) exp_a.push_back(e);
      else exp_b.push_back(e);
    end
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? exp_a.size() : exp_b.size();
  endfunction

  task automatic mon(input int sel, input logic [6:0] o);
    sym_t got, e;
    got = {o[5:4], o[2:0]};
    if (!rst_q) begin
      chk("reset_outputs", {11'd0, o[5:0]}, 16'd0);
    end else if (o[3]) begin
      chk("ireq_before_symbol", {15'd0, ireq_q[sel]}, 16'd1);
      if (qsize(sel) == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_symbol inst%0d: got %b expected none at %0t", sel, got, $time);
      end else begin
        e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
        chk(sel == 0 ? "symbol_a" : "symbol_b", {11'd0, got}, {11'd0, e});
      end
      if (sel == 0) obs_a.push_back(o[5:4]);
      if (sel == 1 && gap_chk && o[2]) chk("b2b_zero_gap", {15'd0, prev_eop_b}, 16'd1);
    end else begin
      chk("flags_without_oval", {13'd0, o[2:0]}, 16'd0);
      chk("odat_hold", {14'd0, o[5:4]}, {14'd0, last_odat[sel]});
    end
    last_odat[sel] = o[5:4];
    if (sel == 1) prev_eop_b = o[3] && o[1];
  endtask

  // Single compare process, away from the active edge
  always @(negedge iclk) begin
    mon(0, {a_oreq, a_odat, a_oval, a_osop, a_oeop, a_oerr});
    mon(1, {b_oreq, b_odat, b_oval, b_osop, b_oeop, b_oerr});
  end

  always @(posedge iclk) begin
    ireq_q[0] <= ireq_v[0];
    ireq_q[1] <= ireq_v[1];
    rst_q     <= irst;
    if (irst && ireq_v[1] && !b_oreq) low_cnt <= low_cnt + 1;
  end

  task automatic cyc(input int sel, input logic v, input logic d, input logic s, output logic acc);
    @(negedge iclk);
    ireq_v[sel] = (sel == 1 && bp) ? ($urandom_range(0, 3) != 0) : 1'b1;
    ival_v[sel] = v;
    idat_v[sel] = d;
    isop_v[sel] = s;
    #1;
    acc = (sel == 0) ? (v && a_oreq) : (v && b_oreq);
  endtask

  task automatic send(input int sel, input logic d, input logic s);
    logic acc;
    int g;
    acc = 1'b0;
    g = 0;
    while (!acc && g < 200) begin
      cyc(sel, 1'b1, d, s, acc);
      g++;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout inst%0d: got no accept expected accept", sel);
    end
  endtask

  task automatic send_frame(input int sel, input bits_t b);
    for (int i = 0; i < b.size(); i++) send(sel, b[i], i == 0);
  endtask

  task automatic drain(input int sel);
    logic acc;
    int g;
    g = 0;
    while (qsize(sel) != 0 && g < 300) begin
      cyc(sel, 1'b0, 1'b0, 1'b0, acc);
      g++;
    end
    chk("drain_empty", 16'(qsize(sel)), 16'd0);
    for (int i = 0; i < 8; i++) cyc(sel, 1'b0, 1'b0, 1'b0, acc);
  endtask

  function automatic logic [13:0] obs_vec();
    logic [13:0] v;
    v = 14'd0;
    for (int i = 0; i < 7 && i < obs_a.size(); i++) v = {v[11:0], obs_a[i]};
    return v;
  endfunction

  initial begin
    bits_t imp, two, zf, f1, f2, pre;
    logic [7:0] by0, by1;
    logic [13:0] v;
    int base;
    for (int i = 0; i < 2; i++) begin
      ival_v[i] = 1'b0;
      idat_v[i] = 1'b0;
      isop_v[i] = 1'b0;
      ireq_v[i] = 1'b1;
      last_odat[i] = 2'b00;
    end

    // Pin the model itself with hand-computed values
    imp.push_back(1'b1);
    v = 14'd0;
    for (int t = 0; t < 7; t++) v = {v[11:0], model_sym(imp, t)};
    chk("model_impulse", {2'd0, v}, {2'd0, 14'b11_10_11_11_00_01_11});
    two.push_back(1'b1);
    two.push_back(1'b1);
    chk("model_two_ones_t1", {14'd0, model_sym(two, 1)}, 16'd1);
    chk("model_tail_zero", {14'd0, model_sym(imp, 7)}, 16'd0);

    // Reset state and combinational oreq
    repeat (3) @(negedge iclk);
    #1;
    chk("rst_oreq_hi", {15'd0, a_oreq}, 16'd1);
    chk("rst_oval", {15'd0, b_oval}, 16'd0);
    chk("rst_odat", {14'd0, b_odat}, 16'd0);
    ireq_v[1] = 1'b0;
    #1;
    chk("rst_oreq_follows_ireq", {15'd0, b_oreq}, 16'd0);
    ireq_v[1] = 1'b1;
    @(negedge iclk);
    irst = 1'b1;

    // Impulse response, FRAME_BITS=1
    obs_a.delete();
    push_frame(0, imp, 1'b1, 1'b0);
    send(0, 1'b1, 1'b1);
    drain(0);
    chk("dut_impulse", {2'd0, obs_vec()}, {2'd0, 14'b11_10_11_11_00_01_11});

    // All-zero frame, FRAME_BITS=16; oreq low exactly during the 6 tail cycles
    for (int i = 0; i < 16; i++) zf.push_back(1'b0);
    base = low_cnt;
    push_frame(1, zf, 1'b1, 1'b0);
    send_frame(1, zf);
    drain(1);
    chk("tail_oreq_low_cycles", 16'(low_cnt - base), 16'd6);

    // Backpressure with two back-to-back random frames
    for (int i = 0; i < 16; i++) begin
      f1.push_back(1'($urandom_range(0, 1)));
      f2.push_back(1'($urandom_range(0, 1)));
    end
    bp = 1'b1;
    push_frame(1, f1, 1'b1, 1'b0);
    push_frame(1, f2, 1'b1, 1'b0);
    send_frame(1, f1);
    send_frame(1, f2);
    drain(1);
    bp = 1'b0;

    // Early isop at bit 5: four bits of the old frame, then a fresh frame with oerr
    for (int i = 0; i < 4; i++) pre.push_back(1'($urandom_range(0, 1)));
    pre[0] = 1'b1;
    push_frame(1, pre, 1'b0, 1'b0);
    push_frame(1, f1, 1'b1, 1'b1);
    send_frame(1, pre);
    send_frame(1, f1);
    drain(1);

    // Back-to-back frames of bytes A5, 3C with continuous valid
    by0 = 8'hA5;
    by1 = 8'h3C;
    f2.delete();
    for (int k = 7; k >= 0; k--) f2.push_back(by0[k]);
    for (int k = 7; k >= 0; k--) f2.push_back(by1[k]);
    push_frame(1, f2, 1'b1, 1'b0);
    push_frame(1, f2, 1'b1, 1'b0);
    send_frame(1, f2);
    gap_chk = 1'b1;
    send_frame(1, f2);
    drain(1);
    gap_chk = 1'b0;

    // Reset pulse mid-TAIL, then a clean impulse again
    push_frame(0, imp, 1'b1, 1'b0);
    send(0, 1'b1, 1'b1);
    drain_two_tail();
    chk("midtail_oval_drop", {15'd0, a_oval}, 16'd0);
    chk("midtail_symbols_left", 16'(exp_a.size()), 16'd4);
    exp_a.delete();
    irst = 1'b1;
    obs_a.delete();
    push_frame(0, imp, 1'b1, 1'b0);
    send(0, 1'b1, 1'b1);
    drain(0);
    chk("dut_impulse_after_reset", {2'd0, obs_vec()}, {2'd0, 14'b11_10_11_11_00_01_11});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic drain_two_tail();
    logic acc;
    cyc(0, 1'b0, 1'b0, 1'b0, acc);
    cyc(0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge iclk);
    irst = 1'b0;
    @(negedge iclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
